mem_initiator: RTL and testbench

Initiator-side controller for the single-port `Mem` word memory. It accepts one load or store request at a time from the CPU datapath over a valid/ready handshake and drives `Mem`'s `addr`/`wdata`/`we` pins. It captures the synchronous read data and returns a response over a second valid/ready handshake. It sits between the CPU core's load/store path and `Mem`, and is the only agent driving `Mem`'s write port.

---
 rtl/mem_initiator_pkg.sv | 26 ++
 rtl/mem_initiator.sv | 143 ++++++++++++++
 tb/tb_mem_initiator.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_initiator_pkg.sv
// ---------------------------------------------------------------------------
// mem_initiator_pkg
//
// Shared definitions for the mem_initiator block: the controller state
// encoding and the default memory geometry.
//
// Optional feature macro used by mem_initiator: MEM_INITIATOR_VERIFY_EN
// ---------------------------------------------------------------------------
package mem_initiator_pkg;

  // Default data word width and number of memory words
  localparam int MEM_INIT_WIDTH = 16;
  localparam int MEM_INIT_DEPTH = 1024;

  // Controller states; VRD/VCAP are only reachable in the verify build
  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    CAP,
    VRD,
    VCAP,
    RSP
  } mem_init_state_t;

endpackage

// File: rtl/mem_initiator.sv
// ---------------------------------------------------------------------------
// mem_initiator
//
// Initiator-side controller for the single-port Mem word memory. Accepts one
// load/store request at a time over a valid/ready handshake, drives the Mem
// address/data/write-enable pins, captures the synchronous read data and
// returns a response over a second valid/ready handshake.
//
// Configuration macro:
//   MEM_INITIATOR_VERIFY_EN  when defined, every store is followed by a
//                            read-back of the same address; the response
//                            carries the read-back value and flags an error
//                            if it differs from the written data.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   req_valid   in   request present
//   req_ready   out  block can accept a request
//   req_we      in   1 = store, 0 = load
//   req_addr    in   word address
//   req_wdata   in   store data
//   resp_valid  out  response present
//   resp_ready  in   consumer accepts response
//   resp_rdata  out  load data; for stores, the written (or read-back) data
//   resp_err    out  error flag for this response
//   mem_addr    out  to Mem.addr
//   mem_wdata   out  to Mem.wdata
//   mem_we      out  to Mem.we
//   mem_out     in   from Mem.out, valid one clock after mem_addr
// ---------------------------------------------------------------------------
module mem_initiator
  import mem_initiator_pkg::*;
#(
  parameter int WIDTH    = MEM_INIT_WIDTH,
  parameter int DEPTH    = MEM_INIT_DEPTH,
  parameter int ADD_SIZE = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADD_SIZE-1:0] req_addr,
  input  logic [WIDTH-1:0]    req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [WIDTH-1:0]    resp_rdata,
  output logic                resp_err,
  output logic [ADD_SIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  output logic                mem_we,
  input  logic [WIDTH-1:0]    mem_out
);

  // One extra bit so the range check also works when DEPTH is a power of two
  localparam logic [ADD_SIZE:0] DepthLimit = (ADD_SIZE + 1)'(DEPTH);

  mem_init_state_t     state_q, state_d;
  logic [ADD_SIZE-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic [WIDTH-1:0]    rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                outOfRange;

  assign outOfRange = ({1'b0, req_addr} >= DepthLimit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Address/data registers only load for in-range requests, so the memory
  // pins keep their last real access while an error response is returned.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          err_d   = outOfRange;
          rdata_d = '0;
          if (outOfRange) begin
            state_d = RSP;
          end else begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            state_d = req_we ? WR : RD;
          end
        end
      end
      WR: begin
`ifdef MEM_INITIATOR_VERIFY_EN
        state_d = VRD;
`else
        rdata_d = wdata_q;
        state_d = RSP;
`endif
      end
      RD:   state_d = CAP;
      CAP: begin
        rdata_d = mem_out;
        state_d = RSP;
      end
      VRD:  state_d = VCAP;
      VCAP: begin
        rdata_d = mem_out;
        err_d   = (mem_out != wdata_q);
        state_d = RSP;
      end
      RSP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // req_ready is gated by rst so nothing looks acceptable while in reset
  assign req_ready  = rst && (state_q == IDLE);
  assign resp_valid = (state_q == RSP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_we     = (state_q == WR);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_initiator.sv
// ---------------------------------------------------------------------------
// tb_mem_initiator
//
// Directed testbench for mem_initiator (DEPTH=1000) with a behavioural
// single-port synchronous memory beside it. Build with
// MEM_INITIATOR_VERIFY_EN defined to exercise the store read-back path.
// ---------------------------------------------------------------------------
module tb_mem_initiator;

  localparam int WIDTH    = 16;
  localparam int DEPTH    = 1000;
  localparam int ADD_SIZE = $clog2(DEPTH);
  localparam int TIMEOUT  = 20;

`ifdef MEM_INITIATOR_VERIFY_EN
  localparam int StoreLat = 3;
`else
  localparam int StoreLat = 1;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic                req_we = 1'b0;
  logic [ADD_SIZE-1:0] req_addr = '0;
  logic [WIDTH-1:0]    req_wdata = '0;
  logic                resp_valid;
  logic                resp_ready = 1'b1;
  logic [WIDTH-1:0]    resp_rdata;
  logic                resp_err;
  logic [ADD_SIZE-1:0] mem_addr;
  logic [WIDTH-1:0]    mem_wdata;
  logic                mem_we;
  logic [WIDTH-1:0]    mem_out;

  int checkCount = 0;
  int failCount  = 0;

  mem_initiator #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .ADD_SIZE(ADD_SIZE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_out   (mem_out)
  );

  always #5 clk = ~clk;

  // Behavioural Mem: synchronous write, registered read one clock later.
  // corruptRead forces the read data to zero to provoke a verify mismatch.
  logic [WIDTH-1:0]    memArray [0:(1<<ADD_SIZE)-1];
  logic [WIDTH-1:0]    memRead = '0;
  logic                corruptRead = 1'b0;
  int                  weCount = 0;
  logic [ADD_SIZE-1:0] weAddr = '0;
  logic [WIDTH-1:0]    weData = '0;

  initial begin
    for (int i = 0; i < (1 << ADD_SIZE); i++) memArray[i] = '0;
  end

  always @(posedge clk) begin
    if (mem_we) begin
      memArray[mem_addr] <= mem_wdata;
      weCount <= weCount + 1;
      weAddr  <= mem_addr;
      weData  <= mem_wdata;
    end
    memRead <= memArray[mem_addr];
  end

  assign mem_out = corruptRead ? '0 : memRead;

  // Watchdog so a stuck run still ends with a report
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Offer a request and return #1 after the accepting edge, request dropped
  task automatic applyStimulus(input logic we, input logic [ADD_SIZE-1:0] addr,
                               input logic [WIDTH-1:0] wdata);
    int waitCycles = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    while (!req_ready && waitCycles < TIMEOUT) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    checkOutput("req_accept_in_time", 32'(waitCycles < TIMEOUT), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Number of edges after the accept edge before resp_valid is visible
  task automatic waitResponse(output int lat);
    lat = 0;
    while (!resp_valid && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Full transaction with resp_ready held high throughout
  task automatic doTransaction(input string tag, input logic we,
                               input logic [ADD_SIZE-1:0] addr,
                               input logic [WIDTH-1:0] wdata, input int expLat,
                               input logic [WIDTH-1:0] expData, input logic expErr,
                               input int expWe);
    int lat;
    resp_ready = 1'b1;
    weCount = 0;
    applyStimulus(we, addr, wdata);
    waitResponse(lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_rdata"}, 32'(resp_rdata), 32'(expData));
    checkOutput({tag, "_err"}, 32'(resp_err), 32'(expErr));
    checkOutput({tag, "_we_cycles"}, 32'(weCount), 32'(expWe));
    if (expWe != 0) begin
      checkOutput({tag, "_we_addr"}, 32'(weAddr), 32'(addr));
      checkOutput({tag, "_we_data"}, 32'(weData), 32'(wdata));
    end
    @(posedge clk); #1;
    checkOutput({tag, "_done_valid"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, "_done_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, "_resp_rdata"}, 32'(resp_rdata), 32'd0);
    checkOutput({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  initial begin
    int lat;

    // Reset values while rst is low
    #1;
    checkResetOutputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_req_ready", 32'(req_ready), 32'd1);

    // Store then loads; load data appears two edges after the accept edge
    doTransaction("st5", 1'b1, 10'd5, 16'hABCD, StoreLat, 16'hABCD, 1'b0, 1);
    doTransaction("ld5", 1'b0, 10'd5, 16'h0000, 2, 16'hABCD, 1'b0, 0);
    doTransaction("st10", 1'b1, 10'd10, 16'h1234, StoreLat, 16'h1234, 1'b0, 1);
    doTransaction("ld10", 1'b0, 10'd10, 16'h0000, 2, 16'h1234, 1'b0, 0);
    doTransaction("ld5b", 1'b0, 10'd5, 16'h0000, 2, 16'hABCD, 1'b0, 0);
    checkOutput("idle_mem_addr_hold", 32'(mem_addr), 32'd5);

    // Backpressure with a second request held valid behind the first
    resp_ready = 1'b0;
    applyStimulus(1'b0, 10'd10, 16'h0000);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 10'd5;
    req_wdata = 16'h0000;
    waitResponse(lat);
    checkOutput("bp_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_valid_held", 32'(resp_valid), 32'd1);
      checkOutput("bp_rdata_held", 32'(resp_rdata), 32'h1234);
      checkOutput("bp_req_ready_low", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_done_valid", 32'(resp_valid), 32'd0);
    checkOutput("bp_done_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("bp_second_accepted", 32'(req_ready), 32'd0);
    waitResponse(lat);
    checkOutput("bp_second_latency", 32'(lat), 32'd2);
    checkOutput("bp_second_rdata", 32'(resp_rdata), 32'hABCD);
    @(posedge clk); #1;

    // Out-of-range accesses: immediate error response, no write strobe
    doTransaction("oor_ld", 1'b0, 10'd1010, 16'h0000, 0, 16'h0000, 1'b1, 0);
    doTransaction("oor_st", 1'b1, 10'd999 + 10'd1, 16'hBEEF, 0, 16'h0000, 1'b1, 0);
    checkOutput("oor_mem_addr_hold", 32'(mem_addr), 32'd5);
    doTransaction("err_clear", 1'b0, 10'd10, 16'h0000, 2, 16'h1234, 1'b0, 0);

    // Asynchronous reset in CAP of a load
    resp_ready = 1'b1;
    applyStimulus(1'b0, 10'd5, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkResetOutputs("midrst");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("midrst_no_resp", 32'(resp_valid), 32'd0);
      checkOutput("midrst_req_ready", 32'(req_ready), 32'd0);
    end
    rst = 1'b1;
    doTransaction("post_rst_ld5", 1'b0, 10'd5, 16'h0000, 2, 16'hABCD, 1'b0, 0);

    // Store to addr 3, then a store whose read-back is corrupted
    doTransaction("st3", 1'b1, 10'd3, 16'h55AA, StoreLat, 16'h55AA, 1'b0, 1);
    corruptRead = 1'b1;
`ifdef MEM_INITIATOR_VERIFY_EN
    doTransaction("st3_bad", 1'b1, 10'd3, 16'h1111, 3, 16'h0000, 1'b1, 1);
`else
    doTransaction("st3_bad", 1'b1, 10'd3, 16'h1111, 1, 16'h1111, 1'b0, 1);
`endif
    corruptRead = 1'b0;
    doTransaction("ld3", 1'b0, 10'd3, 16'h0000, 2, 16'h1111, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
